// File: rtl/sar_scan_pkg.sv
// Shared types and defaults for the SAR channel scan controller.
package sar_scan_pkg;
    localparam int NCH_D  = 18;
    localparam int NBIT_D = 10;
    localparam int SW_D   = 4;
    localparam int CHW    = 5;
    localparam int SMIN   = 2;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        HOLD,
        BIT,
        DONE
    } state_t;
endpackage

// File: rtl/sar_ch_pick.sv
// Round-robin finder: lowest set mask bit above ptr, else lowest set bit.
module sar_ch_pick
    import sar_scan_pkg::*;
#(
    parameter int NCH = NCH_D,
    parameter int CW  = CHW
) (
    input  logic [NCH-1:0] mask,
    input  logic [CW-1:0]  ptr,
    output logic [CW-1:0]  nxt,
    output logic           vld
);
    always_comb begin
        nxt = '0;
        vld = |mask;
        // Descending scans leave the lowest match; above-ptr hits override the wrap pick.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) nxt = CW'(i);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (CW'(i) > ptr)) nxt = CW'(i);
        end
    end
endmodule

// File: rtl/sar_scan_ctl.sv
// Round-robin SAR scan controller driving the shared comparator/DAC.
module sar_scan_ctl
    import sar_scan_pkg::*;
#(
    parameter int NCH  = NCH_D,
    parameter int NBIT = NBIT_D,
    parameter int SW   = SW_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [SW-1:0]    settle_cyc,
    input  logic             comp_o,
    output logic             dac1_en,
    output logic [NBIT-1:0]  dac1,
    output logic [NCH-1:0]   cmp_sel,
    output logic             ad_rst,
    output logic             ad_hold,
    output logic             busy,
    output logic             adc_vld,
    output logic [CHW-1:0]   adc_ch,
    output logic [NBIT-1:0]  adc_dat
);
    localparam int BW = $clog2(NBIT);

    state_t          state_q, state_d;
    logic [CHW-1:0]  ptr_q, ptr_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [NBIT-1:0] res_q, res_d;
    logic [1:0]      sync_q, sync_d;

    logic            dac1_en_q, dac1_en_d;
    logic [NBIT-1:0] dac1_q, dac1_d;
    logic [NCH-1:0]  cmp_sel_q, cmp_sel_d;
    logic            ad_rst_q, ad_rst_d;
    logic            ad_hold_q, ad_hold_d;
    logic            busy_q, busy_d;
    logic            adc_vld_q, adc_vld_d;
    logic [CHW-1:0]  adc_ch_q, adc_ch_d;
    logic [NBIT-1:0] adc_dat_q, adc_dat_d;

    logic [CHW-1:0]  pick_nxt;
    logic            pick_vld;
    logic [SW-1:0]   s_eff;
    logic            phase_end;
    logic            go;
    logic            comp_s;
    logic            act;

    sar_ch_pick #(.NCH(NCH), .CW(CHW)) u_pick (
        .mask (ch_mask),
        .ptr  (ptr_q),
        .nxt  (pick_nxt),
        .vld  (pick_vld)
    );

    assign s_eff     = (settle_cyc < SW'(SMIN)) ? SW'(SMIN) : settle_cyc;
    assign phase_end = (cnt_q == s_eff);
    assign go        = enable && pick_vld;
    assign comp_s    = sync_q[1];
    assign sync_d    = {sync_q[0], comp_o};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = SEL;
                    ptr_d   = pick_nxt;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            SEL: begin
                if (phase_end) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                state_d = BIT;
                bit_d   = BW'(NBIT - 1);
                cnt_d   = '0;
            end
            BIT: begin
                if (phase_end) begin
                    res_d[bit_q] = comp_s;
                    cnt_d        = '0;
                    if (bit_q == '0) state_d = DONE;
                    else             bit_d   = bit_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (go) begin
                    state_d = SEL;
                    ptr_d   = pick_nxt;
                    cnt_d   = '0;
                    res_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Dropping enable aborts any phase; the pointer is kept.
        if (!enable) state_d = IDLE;
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        act       = (state_d != IDLE);
        busy_d    = act;
        dac1_en_d = act;
        cmp_sel_d = act ? ({{(NCH-1){1'b0}}, 1'b1} << ptr_d) : '0;
        ad_rst_d  = (state_d == SEL);
        ad_hold_d = (state_d inside {HOLD, BIT});
        dac1_d    = (state_d == BIT) ? (res_d | (NBIT'(1) << bit_d)) : '0;
        adc_vld_d = (state_d == DONE);
        adc_ch_d  = adc_vld_d ? ptr_d : adc_ch_q;
        adc_dat_d = adc_vld_d ? res_d : adc_dat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= CHW'(NCH - 1);
            cnt_q     <= '0;
            bit_q     <= '0;
            res_q     <= '0;
            sync_q    <= '0;
            dac1_en_q <= 1'b0;
            dac1_q    <= '0;
            cmp_sel_q <= '0;
            ad_rst_q  <= 1'b0;
            ad_hold_q <= 1'b0;
            busy_q    <= 1'b0;
            adc_vld_q <= 1'b0;
            adc_ch_q  <= '0;
            adc_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            res_q     <= res_d;
            sync_q    <= sync_d;
            dac1_en_q <= dac1_en_d;
            dac1_q    <= dac1_d;
            cmp_sel_q <= cmp_sel_d;
            ad_rst_q  <= ad_rst_d;
            ad_hold_q <= ad_hold_d;
            busy_q    <= busy_d;
            adc_vld_q <= adc_vld_d;
            adc_ch_q  <= adc_ch_d;
            adc_dat_q <= adc_dat_d;
        end
    end

    assign dac1_en = dac1_en_q;
    assign dac1    = dac1_q;
    assign cmp_sel = cmp_sel_q;
    assign ad_rst  = ad_rst_q;
    assign ad_hold = ad_hold_q;
    assign busy    = busy_q;
    assign adc_vld = adc_vld_q;
    assign adc_ch  = adc_ch_q;
    assign adc_dat = adc_dat_q;
endmodule

// File: tb/tb_sar_scan_ctl.sv
// Directed bench for sar_scan_ctl with an ideal comparator model (1 LSB = 1 mV).
module tb_sar_scan_ctl;
    logic        clk;
    logic        rst;
    logic        enable;
    logic [17:0] ch_mask;
    logic [3:0]  settle_cyc;
    logic        comp_o;
    logic        dac1_en;
    logic [9:0]  dac1;
    logic [17:0] cmp_sel;
    logic        ad_rst;
    logic        ad_hold;
    logic        busy;
    logic        adc_vld;
    logic [4:0]  adc_ch;
    logic [9:0]  adc_dat;

    int v_in [18];
    int cyc;
    int checks;
    int failures;

    sar_scan_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ch_mask    (ch_mask),
        .settle_cyc (settle_cyc),
        .comp_o     (comp_o),
        .dac1_en    (dac1_en),
        .dac1       (dac1),
        .cmp_sel    (cmp_sel),
        .ad_rst     (ad_rst),
        .ad_hold    (ad_hold),
        .busy       (busy),
        .adc_vld    (adc_vld),
        .adc_ch     (adc_ch),
        .adc_dat    (adc_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        comp_o = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (cmp_sel[i]) comp_o = (v_in[i] >= int'(dac1));
        end
    end

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_vld(input int maxc, output logic got);
        got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (adc_vld) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, adc_vld, dac1_en, ad_rst, ad_hold} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b want 00000", {busy, adc_vld, dac1_en, ad_rst, ad_hold});
        end
        checks++;
        if ({cmp_sel, dac1} !== 28'h0) begin
            failures++;
            $display("FAIL reset_sel_dac: got %h want 0", {cmp_sel, dac1});
        end
        checks++;
        if ({adc_ch, adc_dat} !== 15'h0) begin
            failures++;
            $display("FAIL reset_result: got %h want 0", {adc_ch, adc_dat});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int c0, nrst, nhold;
        logic got;
        do_reset();
        settle_cyc = 4'd3;
        ch_mask = 18'h00008;
        v_in[3] = 500;
        enable = 1'b1;
        c0 = cyc;
        nrst = 0;
        nhold = 0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ad_rst) nrst++;
            if (ad_hold) nhold++;
            if (adc_vld) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (got !== 1'b1) begin
            failures++;
            $display("FAIL single_vld: got %b want 1", got);
        end
        checks++;
        if (cyc - c0 !== 46) begin
            failures++;
            $display("FAIL single_latency: got %0d want 46", cyc - c0);
        end
        checks++;
        if (adc_ch !== 5'd3 || cmp_sel !== 18'h00008) begin
            failures++;
            $display("FAIL single_ch: got ch=%0d sel=%h want ch=3 sel=00008", adc_ch, cmp_sel);
        end
        checks++;
        if (adc_dat !== 10'd500) begin
            failures++;
            $display("FAIL single_dat: got %0d want 500", adc_dat);
        end
        checks++;
        if (nrst !== 4) begin
            failures++;
            $display("FAIL single_ad_rst_cycles: got %0d want 4", nrst);
        end
        checks++;
        if (nhold !== 41) begin
            failures++;
            $display("FAIL single_ad_hold_cycles: got %0d want 41", nhold);
        end
        @(negedge clk);
        checks++;
        if (adc_vld !== 1'b0 || adc_dat !== 10'd500) begin
            failures++;
            $display("FAIL single_pulse: got vld=%b dat=%0d want vld=0 dat=500", adc_vld, adc_dat);
        end
        enable = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_ch [4];
        int exp_dat [4];
        int t [4];
        logic got;
        exp_ch  = '{0, 2, 17, 0};
        exp_dat = '{100, 200, 300, 100};
        do_reset();
        settle_cyc = 4'd3;
        ch_mask = 18'h20005;
        v_in[0] = 100;
        v_in[2] = 200;
        v_in[17] = 300;
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_vld(100, got);
            t[k] = cyc;
            checks++;
            if (got !== 1'b1 || int'(adc_ch) !== exp_ch[k] || int'(adc_dat) !== exp_dat[k]) begin
                failures++;
                $display("FAIL rr_result%0d: got vld=%b ch=%0d dat=%0d want ch=%0d dat=%0d",
                         k, got, adc_ch, adc_dat, exp_ch[k], exp_dat[k]);
            end
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (t[k] - t[k-1] !== 46) begin
                failures++;
                $display("FAIL rr_spacing%0d: got %0d want 46", k, t[k] - t[k-1]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_extremes();
        logic got;
        do_reset();
        settle_cyc = 4'd3;
        ch_mask = 18'h00020;
        v_in[5] = 1023;
        enable = 1'b1;
        wait_vld(100, got);
        checks++;
        if (got !== 1'b1 || adc_ch !== 5'd5 || adc_dat !== 10'h3FF) begin
            failures++;
            $display("FAIL ext_ones: got vld=%b ch=%0d dat=%h want ch=5 dat=3ff", got, adc_ch, adc_dat);
        end
        v_in[5] = 0;
        wait_vld(100, got);
        checks++;
        if (got !== 1'b1 || adc_dat !== 10'h000) begin
            failures++;
            $display("FAIL ext_zeros: got vld=%b dat=%h want dat=000", got, adc_dat);
        end
        enable = 1'b0;
    endtask

    task automatic test_settle();
        int c0, t1;
        logic got;
        do_reset();
        settle_cyc = 4'd0;
        ch_mask = 18'h00002;
        v_in[1] = 777;
        enable = 1'b1;
        c0 = cyc;
        wait_vld(100, got);
        checks++;
        if (got !== 1'b1 || cyc - c0 !== 35 || adc_dat !== 10'd777) begin
            failures++;
            $display("FAIL settle0_first: got vld=%b cyc=%0d dat=%0d want cyc=35 dat=777",
                     got, cyc - c0, adc_dat);
        end
        t1 = cyc;
        wait_vld(100, got);
        checks++;
        if (got !== 1'b1 || cyc - t1 !== 35) begin
            failures++;
            $display("FAIL settle0_period: got vld=%b cyc=%0d want 35", got, cyc - t1);
        end
        do_reset();
        settle_cyc = 4'd15;
        v_in[1] = 42;
        enable = 1'b1;
        c0 = cyc;
        wait_vld(400, got);
        checks++;
        if (got !== 1'b1 || cyc - c0 !== 178 || adc_dat !== 10'd42) begin
            failures++;
            $display("FAIL settle15: got vld=%b cyc=%0d dat=%0d want cyc=178 dat=42",
                     got, cyc - c0, adc_dat);
        end
        enable = 1'b0;
    endtask

    task automatic test_abort();
        logic got, found, vseen;
        do_reset();
        settle_cyc = 4'd3;
        ch_mask = 18'h00011;
        v_in[0] = 600;
        v_in[4] = 250;
        enable = 1'b1;
        found = 1'b0;
        vseen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (adc_vld) vseen = 1'b1;
            if (ad_hold && dac1[5:0] == 6'b100000) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1 || cmp_sel !== 18'h00001) begin
            failures++;
            $display("FAIL abort_reach_bit5: got found=%b sel=%h want found=1 sel=00001", found, cmp_sel);
        end
        enable = 1'b0;
        @(negedge clk);
        if (adc_vld) vseen = 1'b1;
        checks++;
        if ({busy, dac1_en, ad_hold, ad_rst} !== 4'b0 || cmp_sel !== 18'h0) begin
            failures++;
            $display("FAIL abort_idle: got ctl=%b sel=%h want ctl=0000 sel=0",
                     {busy, dac1_en, ad_hold, ad_rst}, cmp_sel);
        end
        repeat (3) begin
            @(negedge clk);
            if (adc_vld) vseen = 1'b1;
        end
        checks++;
        if (vseen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_vld: got %b want 0", vseen);
        end
        enable = 1'b1;
        wait_vld(100, got);
        checks++;
        if (got !== 1'b1 || adc_ch !== 5'd4 || adc_dat !== 10'd250) begin
            failures++;
            $display("FAIL abort_resume: got vld=%b ch=%0d dat=%0d want ch=4 dat=250", got, adc_ch, adc_dat);
        end
        enable = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic got;
        do_reset();
        settle_cyc = 4'd3;
        ch_mask = 18'h00004;
        v_in[2] = 400;
        enable = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ad_hold !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_in_bit: got busy=%b hold=%b want 1 1", busy, ad_hold);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, adc_vld, dac1_en, ad_rst, ad_hold} !== 5'b0 || {cmp_sel, dac1} !== 28'h0) begin
            failures++;
            $display("FAIL rstmid_async: got ctl=%b sel=%h dac=%h want all 0",
                     {busy, adc_vld, dac1_en, ad_rst, ad_hold}, cmp_sel, dac1);
        end
        @(negedge clk);
        ch_mask = 18'h00001;
        v_in[0] = 321;
        rst = 1'b0;
        wait_vld(100, got);
        checks++;
        if (got !== 1'b1 || adc_ch !== 5'd0 || adc_dat !== 10'd321) begin
            failures++;
            $display("FAIL rstmid_first: got vld=%b ch=%0d dat=%0d want ch=0 dat=321", got, adc_ch, adc_dat);
        end
        enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        ch_mask = '0;
        settle_cyc = 4'd3;
        cyc = 0;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 18; i++) v_in[i] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_extremes();
        test_settle();
        test_abort();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
